// File: rtl/frame_check.sv
// frame_check: lock detector for the cyclic P0..P3 training pattern on a 16-bit word stream.
// Define FRAME_CHECK_BYTE_ALIGN_EN to also accept the pattern shifted by half a word.
//
// state  | meaning
// HUNT   | searching for an aligned P0 (or a half-word P0 with the macro)
// VERIFY | counting consecutive matching words toward lock
// LOCKED | aligned; counting consecutive mismatches toward unlock
`timescale 1ns/1ps
module frame_check #(
  parameter int LOCK_WORDS  = 8,
  parameter int UNLOCK_ERRS = 4
) (
  input  logic        rx_clk,
  input  logic        reset,
  input  logic [15:0] rx_data,
  input  logic [1:0]  rxcharisk,
  input  logic        enable,
  output logic        locked,
  output logic        err_pulse,
  output logic [15:0] err_cnt,
  output logic [31:0] word_cnt,
  output logic        byte_offset
);

  localparam int GOOD_W = $clog2(LOCK_WORDS + 1);
  localparam int BAD_W  = $clog2(UNLOCK_ERRS + 1);

  typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;

  state_t            state_q, state_d;
  logic [1:0]        idx_q, idx_d;
  logic [GOOD_W-1:0] good_q, good_d;
  logic [BAD_W-1:0]  bad_q, bad_d;
  logic              offset_q, offset_d;
  logic              err_d, err_inc, word_inc;

  logic [15:0] chk_data;
  logic [1:0]  chk_k;
  logic [15:0] exp_data;
  logic [1:0]  exp_k;
  logic        match, raw_p0;

  always_comb begin
    exp_k = 2'b00;
    case (idx_q)
      2'd0:    begin exp_data = 16'hBCBC; exp_k = 2'b11; end
      2'd1:    exp_data = 16'h5854;
      2'd2:    exp_data = 16'h4034;
      default: exp_data = 16'h23A7;
    endcase
  end

  assign raw_p0 = (rx_data == 16'hBCBC) && (rxcharisk == 2'b11);

`ifdef FRAME_CHECK_BYTE_ALIGN_EN
  logic [7:0] prev_data_q;
  logic       prev_k_q;
  logic       is_p0, half_cand;

  always_ff @(posedge rx_clk or posedge reset) begin
    if (reset) begin
      prev_data_q <= 8'h00;
      prev_k_q    <= 1'b0;
    end else begin
      prev_data_q <= rx_data[15:8];
      prev_k_q    <= rxcharisk[1];
    end
  end

  // Offset words straddle two beats: high byte of the previous one, low byte of this one.
  assign chk_data  = offset_q ? {rx_data[7:0], prev_data_q} : rx_data;
  assign chk_k     = offset_q ? {rxcharisk[0], prev_k_q} : rxcharisk;
  assign is_p0     = (chk_data == 16'hBCBC) && (chk_k == 2'b11);
  assign half_cand = (rxcharisk == 2'b10) && (rx_data[15:8] == 8'hBC);
`else
  assign chk_data = rx_data;
  assign chk_k    = rxcharisk;
`endif

  assign match = (chk_data == exp_data) && (chk_k == exp_k);

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    good_d   = good_q;
    bad_d    = bad_q;
    offset_d = offset_q;
    err_d    = 1'b0;
    err_inc  = 1'b0;
    word_inc = 1'b0;
    if (!enable) begin
      state_d  = HUNT;
      good_d   = '0;
      bad_d    = '0;
      offset_d = 1'b0;
    end else begin
      case (state_q)
        HUNT: begin
`ifdef FRAME_CHECK_BYTE_ALIGN_EN
          if (offset_q && is_p0) begin
            state_d = VERIFY;
            idx_d   = 2'd1;
            good_d  = '0;
          end else if (raw_p0) begin
            state_d  = VERIFY;
            idx_d    = 2'd1;
            good_d   = '0;
            offset_d = 1'b0;
          end else begin
            offset_d = half_cand;
          end
`else
          if (raw_p0) begin
            state_d = VERIFY;
            idx_d   = 2'd1;
            good_d  = '0;
          end
`endif
        end
        VERIFY: begin
          if (match) begin
            idx_d  = idx_q + 2'd1;
            good_d = good_q + GOOD_W'(1);
            if (good_q == GOOD_W'(LOCK_WORDS - 1)) begin
              state_d = LOCKED;
              bad_d   = '0;
            end
          end else begin
            state_d  = HUNT;
            err_d    = 1'b1;
            good_d   = '0;
            offset_d = 1'b0;
          end
        end
        LOCKED: begin
          word_inc = 1'b1;
          idx_d    = idx_q + 2'd1;
          if (match) begin
            bad_d = '0;
          end else begin
            err_d   = 1'b1;
            err_inc = 1'b1;
            if (bad_q == BAD_W'(UNLOCK_ERRS - 1)) begin
              state_d  = HUNT;
              bad_d    = '0;
              good_d   = '0;
              offset_d = 1'b0;
            end else begin
              bad_d = bad_q + BAD_W'(1);
            end
          end
        end
        default: begin
          state_d  = HUNT;
          offset_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge rx_clk or posedge reset) begin
    if (reset) begin
      state_q   <= HUNT;
      idx_q     <= 2'd0;
      good_q    <= '0;
      bad_q     <= '0;
      offset_q  <= 1'b0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
      err_cnt   <= 16'h0000;
      word_cnt  <= 32'h0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      good_q    <= good_d;
      bad_q     <= bad_d;
      offset_q  <= offset_d;
      locked    <= (state_d == LOCKED);
      err_pulse <= err_d;
      if (err_inc && (err_cnt != 16'hFFFF))
        err_cnt <= err_cnt + 16'd1;
      if (word_inc)
        word_cnt <= word_cnt + 32'd1;
    end
  end

  assign byte_offset = offset_q;

endmodule

// File: tb/tb_frame_check.sv
// Testbench for frame_check: scoreboarded word-by-word checks of lock, error and counter behaviour.
// The shifted-stream expectations follow FRAME_CHECK_BYTE_ALIGN_EN.
`timescale 1ns/1ps
module tb_frame_check;

  logic        rx_clk = 1'b0;
  logic        reset;
  logic [15:0] rx_data;
  logic [1:0]  rxcharisk;
  logic        enable;
  logic        locked;
  logic        err_pulse;
  logic [15:0] err_cnt;
  logic [31:0] word_cnt;
  logic        byte_offset;

  frame_check dut (
    .rx_clk      (rx_clk),
    .reset       (reset),
    .rx_data     (rx_data),
    .rxcharisk   (rxcharisk),
    .enable      (enable),
    .locked      (locked),
    .err_pulse   (err_pulse),
    .err_cnt     (err_cnt),
    .word_cnt    (word_cnt),
    .byte_offset (byte_offset)
  );

  always #5 rx_clk = ~rx_clk;

  typedef struct packed {
    logic        lk;
    logic        ep;
    logic [15:0] ec;
    logic [31:0] wc;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          ph = 0;
  logic        exp_lk_prev = 1'b0;
  logic [15:0] exp_ec = 16'h0;
  logic [31:0] exp_wc = 32'h0;
  logic [15:0] pd[4];
  logic [1:0]  pk[4];

  // Push the expected post-edge outputs, then present the word for one edge.
  task automatic send(input logic [15:0] d, input logic [1:0] k, input logic en,
                      input logic lk, input logic ep);
    if (exp_lk_prev && en) exp_wc = exp_wc + 32'd1;
    if (exp_lk_prev && en && ep && exp_ec != 16'hFFFF) exp_ec = exp_ec + 16'd1;
    sb.push_back({lk, ep, exp_ec, exp_wc});
    @(negedge rx_clk);
    rx_data = d;
    rxcharisk = k;
    enable = en;
    @(posedge rx_clk);
    #1;
    exp_lk_prev = lk;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    enable = 1'b1;
    rx_data = 16'h0;
    rxcharisk = 2'b00;
    repeat (2) @(negedge rx_clk);
    reset = 1'b0;
    exp_lk_prev = 1'b0;
    exp_ec = 16'h0;
    exp_wc = 32'h0;
    ph = 0;
    sb.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    enable = 1'b1;
    rx_data = 16'h0;
    rxcharisk = 2'b00;
    #1;
    checks++;
    if ({locked, err_pulse, err_cnt, word_cnt, byte_offset} !== 51'b0) begin
      errors++;
      $display("FAIL reset_async: got lk=%b ep=%b ec=%0d wc=%0d bo=%b, want all 0",
               locked, err_pulse, err_cnt, word_cnt, byte_offset);
    end
    @(posedge rx_clk);
    #1;
    checks++;
    if ({locked, err_pulse, err_cnt, word_cnt, byte_offset} !== 51'b0) begin
      errors++;
      $display("FAIL reset_held: got lk=%b ep=%b ec=%0d wc=%0d bo=%b, want all 0",
               locked, err_pulse, err_cnt, word_cnt, byte_offset);
    end
    do_reset();
  endtask

  task automatic test_lock();
    exp_t e;
    for (int i = 0; i < 15; i++) begin
      if (i < 2) send(16'h0000, 2'b00, 1'b1, 1'b0, 1'b0);
      else begin
        send(pd[ph], pk[ph], 1'b1, (i >= 10), 1'b0);
        ph = (ph + 1) % 4;
      end
      e = sb.pop_front();
      checks++;
      if ({locked, err_pulse, err_cnt, word_cnt} !== e) begin
        errors++;
        $display("FAIL lock word %0d: got lk=%b ep=%b ec=%0d wc=%0d, want lk=%b ep=%b ec=%0d wc=%0d",
                 i, locked, err_pulse, err_cnt, word_cnt, e.lk, e.ep, e.ec, e.wc);
      end
    end
  endtask

  task automatic test_single_err();
    exp_t e;
    bit done = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (!done && ph == 2) begin
        send(16'h4035, 2'b00, 1'b1, 1'b1, 1'b1);
        done = 1'b1;
      end else send(pd[ph], pk[ph], 1'b1, 1'b1, 1'b0);
      ph = (ph + 1) % 4;
      e = sb.pop_front();
      checks++;
      if ({locked, err_pulse, err_cnt, word_cnt} !== e) begin
        errors++;
        $display("FAIL single_err word %0d: got lk=%b ep=%b ec=%0d wc=%0d, want lk=%b ep=%b ec=%0d wc=%0d",
                 i, locked, err_pulse, err_cnt, word_cnt, e.lk, e.ep, e.ec, e.wc);
      end
    end
  endtask

  task automatic test_unlock();
    exp_t e;
    for (int i = 0; i < 13; i++) begin
      if (i < 4) send(16'hFFFF, 2'b00, 1'b1, (i < 3), 1'b1);
      else begin
        if (i == 4) ph = 0;
        send(pd[ph], pk[ph], 1'b1, (i == 12), 1'b0);
        ph = (ph + 1) % 4;
      end
      e = sb.pop_front();
      checks++;
      if ({locked, err_pulse, err_cnt, word_cnt} !== e) begin
        errors++;
        $display("FAIL unlock word %0d: got lk=%b ep=%b ec=%0d wc=%0d, want lk=%b ep=%b ec=%0d wc=%0d",
                 i, locked, err_pulse, err_cnt, word_cnt, e.lk, e.ep, e.ec, e.wc);
      end
    end
  endtask

  // Three bad, one good, four bad: the good word must restart the bad run.
  // Out-of-sequence P0 words serve as the bad words.
  task automatic test_bad_count_reset();
    exp_t e;
    for (int i = 0; i < 8; i++) begin
      if (i == 3) send(pd[ph], pk[ph], 1'b1, 1'b1, 1'b0);
      else if (ph != 0) send(16'hBCBC, 2'b11, 1'b1, (i != 7), 1'b1);
      else send(16'hFFFF, 2'b00, 1'b1, (i != 7), 1'b1);
      ph = (ph + 1) % 4;
      e = sb.pop_front();
      checks++;
      if ({locked, err_pulse, err_cnt, word_cnt} !== e) begin
        errors++;
        $display("FAIL bad_run word %0d: got lk=%b ep=%b ec=%0d wc=%0d, want lk=%b ep=%b ec=%0d wc=%0d",
                 i, locked, err_pulse, err_cnt, word_cnt, e.lk, e.ep, e.ec, e.wc);
      end
    end
  endtask

  task automatic test_verify_err();
    exp_t e;
    ph = 0;
    for (int i = 0; i < 13; i++) begin
      if (i == 1) send(pd[1], 2'b01, 1'b1, 1'b0, 1'b1);
      else send(pd[ph], pk[ph], 1'b1, (i == 12), 1'b0);
      ph = (ph + 1) % 4;
      e = sb.pop_front();
      checks++;
      if ({locked, err_pulse, err_cnt, word_cnt} !== e) begin
        errors++;
        $display("FAIL verify_err word %0d: got lk=%b ep=%b ec=%0d wc=%0d, want lk=%b ep=%b ec=%0d wc=%0d",
                 i, locked, err_pulse, err_cnt, word_cnt, e.lk, e.ep, e.ec, e.wc);
      end
    end
  endtask

  task automatic test_enable();
    exp_t e;
    int seen = -1;
    for (int i = 0; i < 17; i++) begin
      if (i == 0) send(pd[ph], pk[ph], 1'b0, 1'b0, 1'b0);
      else begin
        if (seen < 0 && ph == 0) seen = 0;
        else if (seen >= 0) seen++;
        send(pd[ph], pk[ph], 1'b1, (seen >= 8), 1'b0);
      end
      ph = (ph + 1) % 4;
      e = sb.pop_front();
      checks++;
      if ({locked, err_pulse, err_cnt, word_cnt} !== e) begin
        errors++;
        $display("FAIL enable word %0d: got lk=%b ep=%b ec=%0d wc=%0d, want lk=%b ep=%b ec=%0d wc=%0d",
                 i, locked, err_pulse, err_cnt, word_cnt, e.lk, e.ep, e.ec, e.wc);
      end
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    do_reset();
    for (int i = 0; i < 12; i++) begin
      if (i < 9) begin
        send(pd[ph], pk[ph], 1'b1, (i == 8), 1'b0);
        ph = (ph + 1) % 4;
      end else send(16'hFFFF, 2'b00, 1'b1, 1'b1, 1'b1);
      e = sb.pop_front();
      checks++;
      if ({locked, err_pulse, err_cnt, word_cnt} !== e) begin
        errors++;
        $display("FAIL reset_mid word %0d: got lk=%b ep=%b ec=%0d wc=%0d, want lk=%b ep=%b ec=%0d wc=%0d",
                 i, locked, err_pulse, err_cnt, word_cnt, e.lk, e.ep, e.ec, e.wc);
      end
    end
    @(negedge rx_clk);
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({locked, err_pulse, err_cnt, word_cnt, byte_offset} !== 51'b0) begin
      errors++;
      $display("FAIL reset_mid_async: got lk=%b ep=%b ec=%0d wc=%0d bo=%b, want all 0",
               locked, err_pulse, err_cnt, word_cnt, byte_offset);
    end
    @(negedge rx_clk);
    reset = 1'b0;
    rx_data = pd[0];
    rxcharisk = pk[0];
    exp_lk_prev = 1'b0;
    exp_ec = 16'h0;
    exp_wc = 32'h0;
    sb.delete();
    @(posedge rx_clk);
    #1;
    ph = 1;
    for (int i = 0; i < 8; i++) begin
      send(pd[ph], pk[ph], 1'b1, (i == 7), 1'b0);
      ph = (ph + 1) % 4;
      e = sb.pop_front();
      checks++;
      if ({locked, err_pulse, err_cnt, word_cnt} !== e) begin
        errors++;
        $display("FAIL post_reset word %0d: got lk=%b ep=%b ec=%0d wc=%0d, want lk=%b ep=%b ec=%0d wc=%0d",
                 i, locked, err_pulse, err_cnt, word_cnt, e.lk, e.ep, e.ec, e.wc);
      end
    end
  endtask

  task automatic test_shifted();
    exp_t e;
    logic [7:0] b[8];
    logic       kb[8];
    logic       lk;
    logic       exp_bo;
    b  = '{8'hBC, 8'hBC, 8'h54, 8'h58, 8'h34, 8'h40, 8'hA7, 8'h23};
    kb = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    do_reset();
    for (int i = 0; i < 20; i++) begin
`ifdef FRAME_CHECK_BYTE_ALIGN_EN
      lk = (i >= 12);
`else
      lk = 1'b0;
`endif
      send({b[(2*i+2)%8], b[(2*i+1)%8]}, {kb[(2*i+2)%8], kb[(2*i+1)%8]}, 1'b1, lk, 1'b0);
      e = sb.pop_front();
      checks++;
      if ({locked, err_pulse, err_cnt, word_cnt} !== e) begin
        errors++;
        $display("FAIL shifted word %0d: got lk=%b ep=%b ec=%0d wc=%0d, want lk=%b ep=%b ec=%0d wc=%0d",
                 i, locked, err_pulse, err_cnt, word_cnt, e.lk, e.ep, e.ec, e.wc);
      end
    end
`ifdef FRAME_CHECK_BYTE_ALIGN_EN
    exp_bo = 1'b1;
`else
    exp_bo = 1'b0;
`endif
    checks++;
    if (byte_offset !== exp_bo) begin
      errors++;
      $display("FAIL shifted_byte_offset: got %b, want %b", byte_offset, exp_bo);
    end
  endtask

  initial begin
    pd = '{16'hBCBC, 16'h5854, 16'h4034, 16'h23A7};
    pk = '{2'b11, 2'b00, 2'b00, 2'b00};
    test_reset();
    test_lock();
    test_single_err();
    test_unlock();
    test_bad_count_reset();
    test_verify_err();
    test_enable();
    test_reset_mid();
    test_shifted();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
